// File: rtl/axis_pkt_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkt_gen_pkg
// Purpose  : Shared constants, FSM state type and length helper for the
//            AXI-Stream packet generator.
// Contents : c_BYTES, c_MTY_WIDTH, c_MIN_LEN, c_MAX_LEN, c_BEAT_W,
//            state_t {IDLE, SEND, GAP}, clamp_len()
// Revision : 1.0 - initial release
// ============================================================================
package pkt_gen_pkg;

  localparam int c_BYTES     = 32;
  localparam int c_MTY_WIDTH = 5;
  localparam int c_MIN_LEN   = 64;
  localparam int c_MAX_LEN   = 9600;
  // 9600/32 = 300 beats, so 9 bits cover the largest packet.
  localparam int c_BEAT_W    = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Clamp a requested byte length into [min_len, max_len].
  function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                            input int          min_len,
                                            input int          max_len);
    logic [15:0] res;
    res = len;
    if (len < 16'(min_len)) res = 16'(min_len);
    else if (len > 16'(max_len)) res = 16'(max_len);
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_pkt_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_gen_if
// Purpose  : AXI-Stream bundle (tvalid/tready/tdata/tlast/tuser_mty).
// Modports : master - drives tvalid/tdata/tlast/tuser_mty, samples tready
//            slave  - samples tvalid/tdata/tlast/tuser_mty, drives tready
// Revision : 1.0 - initial release
// ============================================================================
interface axis_pkt_gen_if #(
  parameter int DATA_WIDTH = 256,
  parameter int MTY_WIDTH  = 5
);

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic [MTY_WIDTH-1:0]  tuser_mty;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    output tuser_mty,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    input  tuser_mty,
    output tready
  );

endinterface
`default_nettype wire

// File: rtl/axis_pkt_gen_beat_fmt.sv
`default_nettype none
// ============================================================================
// Module   : pkt_gen_beat_fmt
// Purpose  : Combinational beat formatter. Builds one tdata word from the
//            beat index and packet seed: byte k of the packet is
//            (k + seed) mod 256, byte 0 of the beat in the MSB lane, empty
//            bytes of the last beat (LSB end) forced to zero.
// Macro    : PKT_GEN_SEQ_HDR_EN - when defined, bytes 0..3 of beat 0 carry
//            the 32-bit sequence number, big-endian.
// Ports    : beat_idx  in  beat number within the packet
//            seed      in  pattern seed for this packet
//            mty       in  empty-byte count (meaningful when is_last)
//            is_last   in  this is the final beat of the packet
//            seq       in  sequence number (only with PKT_GEN_SEQ_HDR_EN)
//            tdata     out formatted beat
// Revision : 1.0 - initial release
// ============================================================================
module pkt_gen_beat_fmt
  import pkt_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int MTY_WIDTH  = 5
) (
  input  wire logic [c_BEAT_W-1:0]   beat_idx,
  input  wire logic [7:0]            seed,
  input  wire logic [MTY_WIDTH-1:0]  mty,
  input  wire logic                  is_last,
`ifdef PKT_GEN_SEQ_HDR_EN
  input  wire logic [31:0]           seq,
`endif
  output logic      [DATA_WIDTH-1:0] tdata
);

  localparam int c_NB = DATA_WIDTH / 8;

  // Low byte of the packet offset of this beat's byte 0.
  logic [7:0] w_base;
  assign w_base = 8'(32'(beat_idx) * c_NB);

`ifdef PKT_GEN_SEQ_HDR_EN
  logic w_first;
  assign w_first = (beat_idx == '0);
`endif

  for (genvar j = 0; j < c_NB; j++) begin : g_byte
    logic [7:0] w_pat;
    logic       w_empty;

    assign w_pat   = w_base + 8'(j) + seed;
    // Lane j is empty on the last beat when j >= BYTES - mty.
    assign w_empty = is_last && ((32'(mty) + 32'(j)) >= 32'(c_NB));

`ifdef PKT_GEN_SEQ_HDR_EN
    if (j < 4) begin : g_hdr
      assign tdata[DATA_WIDTH-1-8*j -: 8] = w_first ? seq[31-8*j -: 8]
                                          : (w_empty ? 8'h00 : w_pat);
    end else begin : g_pat
      assign tdata[DATA_WIDTH-1-8*j -: 8] = w_empty ? 8'h00 : w_pat;
    end
`else
    assign tdata[DATA_WIDTH-1-8*j -: 8] = w_empty ? 8'h00 : w_pat;
`endif
  end

endmodule
`default_nettype wire

// File: rtl/axis_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_gen
// Purpose  : AXI-Stream packet transmitter. Sends pkt_count packets (0 =
//            continuous) of clamped length pkt_len with a deterministic byte
//            pattern and ifg_cycles idle cycles between packets.
// Macro    : PKT_GEN_SEQ_HDR_EN - adds a big-endian 32-bit sequence number
//            in bytes 0..3 of each packet.
// Ports    : clk, reset (sync, active-low)
//            start/stop      in   control
//            pkt_len         in   16-bit byte length, latched on start
//            pkt_count       in   packets to send, 0 = until stop
//            ifg_cycles      in   idle cycles between packets
//            busy/done       out  status, done is a one-cycle pulse
//            pkts_sent       out  packets completed since last start
//            m_axis          AXI-Stream master (tvalid/tdata/tlast/
//                            tuser_mty out, tready in)
// Revision : 1.0 - initial release
// ============================================================================
module axis_pkt_gen
  import pkt_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int MTY_WIDTH  = c_MTY_WIDTH,
  parameter int MIN_LEN    = c_MIN_LEN,
  parameter int MAX_LEN    = c_MAX_LEN
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        start,
  input  wire logic        stop,
  input  wire logic [15:0] pkt_len,
  input  wire logic [31:0] pkt_count,
  input  wire logic [7:0]  ifg_cycles,
  output logic             busy,
  output logic             done,
  output logic      [31:0] pkts_sent,
  axis_pkt_gen_if.master   m_axis
);

  localparam int c_NB = DATA_WIDTH / 8;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                  r_state;
  logic [c_BEAT_W-1:0]     r_beats;
  logic [MTY_WIDTH-1:0]    r_last_mty;
  logic [31:0]             r_pkt_count;
  logic [7:0]              r_ifg;
  logic [7:0]              r_gap_cnt;
  logic [c_BEAT_W-1:0]     r_beat_idx;
  logic [31:0]             r_pkts_sent;
  logic                    r_stop_pend;
  logic                    r_done;
  logic                    r_tvalid;
  logic [DATA_WIDTH-1:0]   r_tdata;
  logic                    r_tlast;
  logic [MTY_WIDTH-1:0]    r_mty;

  // --------------------------------------------------------------------------
  // Length decode of the live pkt_len input (used only at start)
  // --------------------------------------------------------------------------
  logic [15:0]             w_len;
  logic [15:0]             w_len_rnd;
  logic [c_BEAT_W-1:0]     w_cfg_beats;
  logic [MTY_WIDTH-1:0]    w_cfg_mty;

  assign w_len       = clamp_len(pkt_len, MIN_LEN, MAX_LEN);
  assign w_len_rnd   = w_len + 16'(c_NB - 1);
  assign w_cfg_beats = c_BEAT_W'(w_len_rnd / 16'(c_NB));
  // beats*BYTES - len is just (-len) mod BYTES.
  assign w_cfg_mty   = MTY_WIDTH'(16'd0 - w_len);

  // --------------------------------------------------------------------------
  // Handshake and decisions
  // --------------------------------------------------------------------------
  logic        w_hs;
  logic        w_stop_req;
  logic [31:0] w_pkts_inc;
  logic        w_finish;

  assign w_hs       = r_tvalid && m_axis.tready;
  assign w_stop_req = r_stop_pend || stop;
  assign w_pkts_inc = r_pkts_sent + 32'd1;
  assign w_finish   = ((r_pkt_count != 32'd0) && (w_pkts_inc == r_pkt_count))
                    || w_stop_req;

  // --------------------------------------------------------------------------
  // Next-beat descriptor. Whenever a beat is loaded it is either the next
  // beat of the current packet (SEND, not last) or beat 0 of a new packet.
  // A new packet directly after a last-beat handshake uses the incremented
  // packet count as its seed, since r_pkts_sent updates on that same edge.
  // --------------------------------------------------------------------------
  logic [c_BEAT_W-1:0]     w_nx_idx;
  logic [c_BEAT_W-1:0]     w_nx_beats;
  logic [MTY_WIDTH-1:0]    w_nx_mty_cfg;
  logic                    w_nx_last;
  logic [MTY_WIDTH-1:0]    w_nx_mty;
  logic [7:0]              w_nx_seed;
  logic [DATA_WIDTH-1:0]   w_fmt_data;

  assign w_nx_idx     = ((r_state == SEND) && !r_tlast) ? r_beat_idx + 1'b1 : '0;
  assign w_nx_beats   = (r_state == IDLE) ? w_cfg_beats : r_beats;
  assign w_nx_mty_cfg = (r_state == IDLE) ? w_cfg_mty : r_last_mty;
  assign w_nx_last    = (w_nx_idx == (w_nx_beats - 1'b1));
  assign w_nx_mty     = w_nx_last ? w_nx_mty_cfg : '0;
  assign w_nx_seed    = (r_state == IDLE)               ? 8'd0 :
                        ((r_state == SEND) && r_tlast)  ? r_pkts_sent[7:0] + 8'd1 :
                                                          r_pkts_sent[7:0];

`ifdef PKT_GEN_SEQ_HDR_EN
  logic [31:0] w_nx_seq;
  assign w_nx_seq = (r_state == IDLE)              ? 32'd0 :
                    ((r_state == SEND) && r_tlast) ? w_pkts_inc :
                                                     r_pkts_sent;
`endif

  pkt_gen_beat_fmt #(
    .DATA_WIDTH (DATA_WIDTH),
    .MTY_WIDTH  (MTY_WIDTH)
  ) u_fmt (
    .beat_idx (w_nx_idx),
    .seed     (w_nx_seed),
    .mty      (w_nx_mty),
    .is_last  (w_nx_last),
`ifdef PKT_GEN_SEQ_HDR_EN
    .seq      (w_nx_seq),
`endif
    .tdata    (w_fmt_data)
  );

  // --------------------------------------------------------------------------
  // FSM, counters and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_beats     <= '0;
      r_last_mty  <= '0;
      r_pkt_count <= '0;
      r_ifg       <= '0;
      r_gap_cnt   <= '0;
      r_beat_idx  <= '0;
      r_pkts_sent <= '0;
      r_stop_pend <= 1'b0;
      r_done      <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tlast     <= 1'b0;
      r_mty       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_stop_pend <= 1'b0;
          if (start) begin
            r_beats     <= w_cfg_beats;
            r_last_mty  <= w_cfg_mty;
            r_pkt_count <= pkt_count;
            r_ifg       <= ifg_cycles;
            r_pkts_sent <= '0;
            r_beat_idx  <= w_nx_idx;
            r_tvalid    <= 1'b1;
            r_tdata     <= w_fmt_data;
            r_tlast     <= w_nx_last;
            r_mty       <= w_nx_mty;
            r_state     <= SEND;
          end
        end

        SEND: begin
          if (stop) r_stop_pend <= 1'b1;
          if (w_hs) begin
            if (r_tlast && (w_finish || (r_ifg != 8'd0))) begin
              // Packet complete and the bus goes idle.
              r_pkts_sent <= w_pkts_inc;
              r_tvalid    <= 1'b0;
              r_tdata     <= '0;
              r_tlast     <= 1'b0;
              r_mty       <= '0;
              if (w_finish) begin
                r_done  <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_gap_cnt <= r_ifg - 8'd1;
                r_state   <= GAP;
              end
            end else begin
              // Next beat, either within this packet or back-to-back
              // into the next one.
              if (r_tlast) r_pkts_sent <= w_pkts_inc;
              r_beat_idx <= w_nx_idx;
              r_tdata    <= w_fmt_data;
              r_tlast    <= w_nx_last;
              r_mty      <= w_nx_mty;
            end
          end
        end

        GAP: begin
          if (w_stop_req) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (r_gap_cnt == 8'd0) begin
            r_beat_idx <= w_nx_idx;
            r_tvalid   <= 1'b1;
            r_tdata    <= w_fmt_data;
            r_tlast    <= w_nx_last;
            r_mty      <= w_nx_mty;
            r_state    <= SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy             = (r_state != IDLE);
  assign done             = r_done;
  assign pkts_sent        = r_pkts_sent;
  assign m_axis.tvalid    = r_tvalid;
  assign m_axis.tdata     = r_tdata;
  assign m_axis.tlast     = r_tlast;
  assign m_axis.tuser_mty = r_mty;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pkt_gen
// Purpose  : Self-checking directed bench for axis_pkt_gen (256-bit bus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [31:0] pkt_count = '0;
  logic [7:0]  ifg_cycles = '0;
  logic        busy;
  logic        done;
  logic [31:0] pkts_sent;

  axis_pkt_gen_if #(.DATA_WIDTH(256), .MTY_WIDTH(5)) axis_if ();

  axis_pkt_gen dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .pkt_len    (pkt_len),
    .pkt_count  (pkt_count),
    .ifg_cycles (ifg_cycles),
    .busy       (busy),
    .done       (done),
    .pkts_sent  (pkts_sent),
    .m_axis     (axis_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int done_cnt = 0;

  logic [255:0] q_data[$];
  logic         q_last[$];
  logic [4:0]   q_mty[$];
  int           q_cyc[$];

  logic         p_stall = 1'b0;
  logic [255:0] p_data = '0;
  logic         p_last = 1'b0;
  logic [4:0]   p_mty = '0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beat monitor on the falling edge: logs beats that will handshake on the
  // next rising edge and checks hold-stability across stalls.
  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (p_stall) begin
      check("stall_valid", 256'(axis_if.tvalid), 256'(1));
      check("stall_data", axis_if.tdata, p_data);
      check("stall_last", 256'(axis_if.tlast), 256'(p_last));
      check("stall_mty", 256'(axis_if.tuser_mty), 256'(p_mty));
    end
    p_stall = axis_if.tvalid && !axis_if.tready;
    p_data  = axis_if.tdata;
    p_last  = axis_if.tlast;
    p_mty   = axis_if.tuser_mty;
    if (axis_if.tvalid && axis_if.tready) begin
      q_data.push_back(axis_if.tdata);
      q_last.push_back(axis_if.tlast);
      q_mty.push_back(axis_if.tuser_mty);
      q_cyc.push_back(cyc);
    end
  end

  // Expected beat b of a packet of (already clamped) length len.
  function automatic logic [255:0] exp_beat(input int len, input int seq, input int b);
    logic [255:0] d;
    d = '0;
    for (int j = 0; j < 32; j++) begin
      int k;
      k = b * 32 + j;
      if (k < len) d[255-8*j -: 8] = 8'((k + seq) & 255);
`ifdef PKT_GEN_SEQ_HDR_EN
      if (b == 0 && j < 4) d[255-8*j -: 8] = 8'(seq >> (24 - 8 * j));
`endif
    end
    return d;
  endfunction

  task automatic clear_q();
    q_data.delete();
    q_last.delete();
    q_mty.delete();
    q_cyc.delete();
  endtask

  task automatic do_start(input int len, input int count, input int ifg);
    @(posedge clk); #1;
    pkt_len    = 16'(len);
    pkt_count  = 32'(count);
    ifg_cycles = 8'(ifg);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    check("tvalid_rise", 256'(axis_if.tvalid), 256'(1));
  endtask

  task automatic wait_done(input string tag, input int base, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (done_cnt > base) break;
      @(posedge clk); #1;
    end
    check({tag, "_done"}, 256'(done_cnt - base), 256'(1));
  endtask

  task automatic check_pkts(input string tag, input int len, input int beats,
                            input int npk, input int first_seq);
    check({tag, "_nbeats"}, 256'(q_data.size()), 256'(beats * npk));
    for (int p = 0; p < npk; p++) begin
      for (int b = 0; b < beats; b++) begin
        int idx;
        idx = p * beats + b;
        if (idx < q_data.size()) begin
          check({tag, "_data"}, q_data[idx], exp_beat(len, first_seq + p, b));
          check({tag, "_last"}, 256'(q_last[idx]), 256'(b == beats - 1));
          check({tag, "_mty"}, 256'(q_mty[idx]),
                256'((b == beats - 1) ? (beats * 32 - len) : 0));
        end
      end
    end
  endtask

  initial begin
    int base;
    logic [255:0] hand;
    axis_if.tready = 1'b1;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 256'(axis_if.tvalid), 256'(0));
    check("rst_tdata", axis_if.tdata, 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_pkts", 256'(pkts_sent), 256'(0));
    reset = 1'b1;

    // ---- len=100, single packet, back-to-back beats
    clear_q();
    base = done_cnt;
    do_start(100, 1, 0);
    wait_done("t1", base, 100);
    check_pkts("t1", 100, 4, 1, 0);
`ifdef PKT_GEN_SEQ_HDR_EN
    hand = 256'h00000000_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
`else
    hand = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
`endif
    if (q_data.size() >= 4) begin
      check("t1_beat0_hand", q_data[0], hand);
      check("t1_beat3_hand", q_data[3], {32'h60616263, 224'h0});
      check("t1_mty_hand", 256'(q_mty[3]), 256'(28));
      check("t1_nobubble", 256'(q_cyc[3] - q_cyc[0]), 256'(3));
    end
    check("t1_pkts", 256'(pkts_sent), 256'(1));
    check("t1_busy", 256'(busy), 256'(0));

    // ---- len=64, len=65, len=10 (clamped)
    clear_q();
    base = done_cnt;
    do_start(64, 1, 0);
    wait_done("t2a", base, 100);
    check_pkts("t2a", 64, 2, 1, 0);

    clear_q();
    base = done_cnt;
    do_start(65, 1, 0);
    wait_done("t2b", base, 100);
    check_pkts("t2b", 65, 3, 1, 0);
    if (q_data.size() >= 3) check("t2b_last_hand", q_data[2], {8'h40, 248'h0});

    clear_q();
    base = done_cnt;
    do_start(10, 1, 0);
    wait_done("t2c", base, 100);
    check_pkts("t2c", 64, 2, 1, 0);

    // ---- count=3, ifg=3
    clear_q();
    base = done_cnt;
    do_start(64, 3, 3);
    wait_done("t3", base, 200);
    check_pkts("t3", 64, 2, 3, 0);
    if (q_data.size() >= 6) begin
      check("t3_gap1", 256'(q_cyc[2] - q_cyc[1]), 256'(4));
      check("t3_gap2", 256'(q_cyc[4] - q_cyc[3]), 256'(4));
`ifndef PKT_GEN_SEQ_HDR_EN
      check("t3_pkt2_byte0", 256'(q_data[2][255:248]), 256'(8'h01));
`endif
    end
    check("t3_pkts", 256'(pkts_sent), 256'(3));

    // ---- tready toggled 1,0,0,1 over len=200
    clear_q();
    base = done_cnt;
    do_start(200, 1, 0);
    for (int i = 0; i < 300; i++) begin
      if (done_cnt > base) break;
      axis_if.tready = (i % 4 == 0) || (i % 4 == 3);
      @(posedge clk); #1;
    end
    axis_if.tready = 1'b1;
    check("t4_done", 256'(done_cnt - base), 256'(1));
    check_pkts("t4", 200, 7, 1, 0);

    // ---- continuous mode, stop on beat 2 of packet 5
    clear_q();
    base = done_cnt;
    do_start(100, 0, 0);
    for (int i = 0; i < 200; i++) begin
      if (q_data.size() >= 17) break;
      @(posedge clk); #1;
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done("t5", base, 100);
    repeat (5) @(posedge clk);
    #1;
    check("t5_done_once", 256'(done_cnt - base), 256'(1));
    check_pkts("t5", 100, 4, 5, 0);
    if (q_data.size() >= 20) check("t5_nobubble", 256'(q_cyc[19] - q_cyc[0]), 256'(19));
    check("t5_pkts", 256'(pkts_sent), 256'(5));

    // ---- reset mid-packet, then clean restart
    clear_q();
    do_start(100, 1, 0);
    for (int i = 0; i < 50; i++) begin
      if (q_data.size() >= 1) break;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    check("t6_tvalid", 256'(axis_if.tvalid), 256'(0));
    check("t6_tdata", axis_if.tdata, 256'(0));
    check("t6_tlast", 256'(axis_if.tlast), 256'(0));
    check("t6_mty", 256'(axis_if.tuser_mty), 256'(0));
    check("t6_busy", 256'(busy), 256'(0));
    check("t6_done", 256'(done), 256'(0));
    check("t6_pkts", 256'(pkts_sent), 256'(0));
    reset = 1'b1;
    clear_q();
    base = done_cnt;
    do_start(64, 1, 0);
    wait_done("t6r", base, 100);
    check_pkts("t6r", 64, 2, 1, 0);
    if (q_data.size() >= 1) check("t6r_byte0", 256'(q_data[0][255:248]), 256'(8'h00));
    check("t6r_pkts", 256'(pkts_sent), 256'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_pkt_gen.md
Name: axis_pkt_gen

Overview:
- AXI-Stream packet transmitter that drives the s_axis side of the queue block, using the same tdata/tlast/tuser_mty framing.
- Generates configurable-length packets with a deterministic byte pattern, an inter-packet gap and a packet count.
- Used as the traffic source for queue/datapath bring-up and throughput measurement.

Parameters:
- DATA_WIDTH, 256, tdata width in bits; BYTES = DATA_WIDTH/8.
- MTY_WIDTH, 5, tuser_mty width; equals log2(BYTES).
- MIN_LEN, 64, minimum packet length in bytes; smaller requests are clamped up to it.
- MAX_LEN, 9600, maximum packet length in bytes; larger requests are clamped down to it.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; latches the config and begins generation when IDLE; ignored otherwise.
- stop  in  1  request to end generation after the current packet completes.
- pkt_len  in  16  packet length in bytes; latched on start.
- pkt_count  in  32  number of packets to send; 0 means continuous.
- ifg_cycles  in  8  idle cycles inserted between packets; latched on start.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- pkts_sent  out  32  packets completed since the last start.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tdata  out  DATA_WIDTH  beat data.
- m_axis_tlast  out  1  last beat of the packet.
- m_axis_tuser_mty  out  MTY_WIDTH  count of empty bytes on the last beat; 0 on all other beats.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset (reset==0 at a clk edge): tvalid=0, tdata=0, tlast=0, tuser_mty=0, busy=0, done=0, pkts_sent=0, state=IDLE. Applies mid-packet as well; the partial packet is abandoned.
- Length handling: len = clamp(pkt_len, MIN_LEN, MAX_LEN).
  - beats = ceil(len/BYTES).
  - mty on the last beat = beats*BYTES - len, range 0..BYTES-1.
- Byte order: byte 0 of a beat sits at tdata[DATA_WIDTH-1 -: 8]. Empty bytes are at the LSB end and are driven to 0.
- Pattern: packet byte k = (k + seed) mod 256, with seed = pkts_sent[7:0] at packet start.
- FSM states: IDLE, SEND, GAP.
  - IDLE: on start, latch config, clear pkts_sent, go to SEND. tvalid rises on the next cycle.
  - SEND: tvalid=1. A beat advances only on tvalid&&tready; tdata/tlast/mty stay stable while tready=0.
  - SEND, last-beat handshake: pkts_sent increments. Then:
    - go to IDLE (pulse done) if pkt_count!=0 and pkts_sent+1==pkt_count, or if stop is pending;
    - otherwise go to GAP when ifg_cycles>0, or stay in SEND with the next packet's first beat on the following cycle when ifg_cycles==0.
  - GAP: tvalid=0 for exactly ifg_cycles cycles, then SEND. If stop is pending, go to IDLE immediately and pulse done.
- stop handling: sampled in any state and held pending until IDLE. It never truncates a packet, so tlast is always delivered. stop while IDLE has no effect.
- Throughput: with tready held at 1 and ifg_cycles=0, the block sends one beat per cycle with no bubbles between packets.
- Counters: beat counter is 9 bits (MAX_LEN/BYTES < 512). pkts_sent wraps modulo 2^32. In continuous mode the block runs until stop.

Optional Feature:
- Macro PKT_GEN_SEQ_HDR_EN.
  - Defined: first beat bytes 0..3 carry the 32-bit packet sequence number (pkts_sent at packet start), big-endian. These replace the pattern bytes; all other bytes follow the pattern.
  - Undefined: every byte follows the pattern; no sequence logic is synthesised.

Decomposition:
- Package pkt_gen_pkg holds BYTES, MTY_WIDTH, MIN_LEN, MAX_LEN and the state enum {IDLE, SEND, GAP}.
- One sub-module, pkt_gen_beat_fmt: combinational formatter taking (beat index, seed, mty, is_last, seq) and producing tdata with pattern, zero fill and optional header. The FSM, counters and handshake stay in axis_pkt_gen.

Test Plan:
- len=100, count=1, ifg=0, tready=1 -> 4 beats; tlast on beat 4 with mty=28; beat 0 bytes 0x00..0x1F; bytes 4..31 of beat 4 are zero; done pulse; pkts_sent=1.
- len=64 then len=65 (separate starts) -> 2 beats with mty=0, then 3 beats with mty=31; len=10 clamps to 64 -> 2 beats, mty=0.
- count=3, ifg=3, tready=1 -> exactly 3 tvalid=0 cycles between each tlast handshake and the next first beat; second packet byte 0=0x01; pkts_sent=3.
- tready toggled 1,0,0,1,... over a len=200 packet -> tdata/tlast/mty stable whenever tvalid&&!tready; 7 beats accepted; final mty=24; no beat lost or duplicated.
- count=0, stop asserted on beat 2 of packet 5 -> packet 5 completes with tlast, then IDLE; pkts_sent=5; done pulses once.
- reset driven low on beat 2 mid-packet -> on the next edge all outputs are 0 and state is IDLE; a subsequent start begins cleanly at byte 0x00.
